// File: rtl/aes_pkg.sv
// Shared AES sequencer types and widths: state encoding, key width, round count and round-number width.
package aes_pkg;

  localparam int unsigned AES_KEY_W     = 128;
  localparam int unsigned AES128_ROUNDS = 10;
  localparam int unsigned AES_RND_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEXP  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ROUND = 3'd3,
    ST_HOLD  = 3'd4
  } aes_state_e;

endpackage

// File: rtl/aes_key_cache.sv
// Remembers the last accepted key and whether its schedule has been expanded;
// o_hit_c flags a request whose key can reuse the round keys already held by the expansion unit.
module aes_key_cache
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [AES_KEY_W-1:0] i_key,
  input  logic                 i_set_valid,
  output logic                 o_hit_c
);

  logic [AES_KEY_W-1:0] r_key_q;
  logic                 r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_q <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_load) begin
        r_key_q <= i_key;
      end
      if (i_set_valid) begin
        r_valid <= 1'b1;
      end
    end
  end

  assign o_hit_c = r_valid && (r_key_q == i_key);

endmodule

// File: rtl/aes_round_sequencer.sv
// Sequences one AES-128 block: request handshake, key expansion, load, NUM_ROUNDS rounds, result hold.
// Define AES_KEY_CACHE_EN to skip key expansion when a request reuses the last expanded key.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_KEY_W-1:0] in_key,
  output logic                 kexp_start,
  input  logic                 kexp_done,
  output logic                 round_load,
  output logic                 round_en,
  output logic [AES_RND_W-1:0] round_num,
  output logic                 final_round,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     block_count
);

  localparam logic [AES_RND_W-1:0] LAST_RND = AES_RND_W'(NUM_ROUNDS);

  aes_state_e           r_state, w_state_nxt;
  logic [AES_RND_W-1:0] r_round_num, w_round_nxt;
  logic [CNT_W-1:0]     r_block_count, w_count_nxt;
  logic                 r_in_ready, r_kexp_start, r_round_load, r_round_en;
  logic                 r_final_round, r_out_valid, r_busy;
  logic                 w_hit;

`ifdef AES_KEY_CACHE_EN
  logic w_cache_load, w_cache_set;

  assign w_cache_load = (r_state == ST_IDLE) && in_valid;
  assign w_cache_set  = (r_state == ST_KEXP) && kexp_done;

  aes_key_cache u_key_cache (
    .clk         (clk),
    .rst_n       (reset),
    .i_load      (w_cache_load),
    .i_key       (in_key),
    .i_set_valid (w_cache_set),
    .o_hit_c     (w_hit)
  );
`else
  logic w_unused_key;

  assign w_unused_key = ^in_key;
  assign w_hit        = 1'b0;
`endif

  // Next state and counters; in_ready is exactly "state is IDLE"
  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round_num;
    w_count_nxt = r_block_count;
    case (r_state)
      ST_IDLE: begin
        w_round_nxt = '0;
        if (in_valid) begin
          w_state_nxt = w_hit ? ST_LOAD : ST_KEXP;
        end
      end
      ST_KEXP: begin
        if (kexp_done) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_ROUND;
        w_round_nxt = AES_RND_W'(1);
      end
      ST_ROUND: begin
        if (r_round_num == LAST_RND) begin
          w_state_nxt = ST_HOLD;
          w_round_nxt = '0;
        end else begin
          w_round_nxt = r_round_num + AES_RND_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = r_block_count + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_round_nxt = '0;
      end
    endcase
  end

  // Moore outputs are registered, decoded from the next state so they align with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_round_num   <= '0;
      r_block_count <= '0;
      r_in_ready    <= 1'b1;
      r_kexp_start  <= 1'b0;
      r_round_load  <= 1'b0;
      r_round_en    <= 1'b0;
      r_final_round <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_round_num   <= w_round_nxt;
      r_block_count <= w_count_nxt;
      r_in_ready    <= (w_state_nxt == ST_IDLE);
      r_kexp_start  <= (w_state_nxt == ST_KEXP) && (r_state != ST_KEXP);
      r_round_load  <= (w_state_nxt == ST_LOAD);
      r_round_en    <= (w_state_nxt == ST_ROUND);
      r_final_round <= (w_state_nxt == ST_ROUND) && (w_round_nxt == LAST_RND);
      r_out_valid   <= (w_state_nxt == ST_HOLD);
      r_busy        <= (w_state_nxt != ST_IDLE);
    end
  end

  assign in_ready    = r_in_ready;
  assign kexp_start  = r_kexp_start;
  assign round_load  = r_round_load;
  assign round_en    = r_round_en;
  assign round_num   = r_round_num;
  assign final_round = r_final_round;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign block_count = r_block_count;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: timeline model checked every cycle plus directed literal checks.
// Expectations adapt to AES_KEY_CACHE_EN when it is defined.
module tb_aes_round_sequencer;
  import aes_pkg::*;

  localparam int unsigned NR    = 10;
  localparam int unsigned CNT_W = 16;
`ifdef AES_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [AES_KEY_W-1:0] in_key = '0;
  logic                 kexp_start;
  logic                 kexp_done = 1'b0;
  logic                 round_load;
  logic                 round_en;
  logic [AES_RND_W-1:0] round_num;
  logic                 final_round;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 busy;
  logic [CNT_W-1:0]     block_count;

  int n_cmp = 0;
  int n_err = 0;
  int kdelay = 3;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NUM_ROUNDS(NR), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
    .kexp_start(kexp_start), .kexp_done(kexp_done), .round_load(round_load), .round_en(round_en),
    .round_num(round_num), .final_round(final_round), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .block_count(block_count)
  );

  function void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function void timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endfunction

  // Timeline model: cycle index since handshake (cycle 1 follows the handshake edge)
  bit               m_active = 1'b0;
  bit               m_miss = 1'b0;
  bit               m_cvalid = 1'b0;
  int               m_c = 0;
  int               m_load = -1;
  logic [127:0]     m_ckey = '0;
  logic [CNT_W-1:0] m_count = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_miss   <= 1'b0;
      m_cvalid <= 1'b0;
      m_c      <= 0;
      m_load   <= -1;
      m_count  <= '0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1;
        m_c      <= 1;
        m_miss   <= !(CACHE && m_cvalid && (m_ckey == in_key));
        m_load   <= (CACHE && m_cvalid && (m_ckey == in_key)) ? 1 : -1;
        m_ckey   <= in_key;
      end
    end else begin
      if (m_load < 0 && kexp_done) begin
        m_load   <= m_c + 1;
        m_cvalid <= 1'b1;
      end else if (m_load > 0 && m_c > m_load + NR && out_ready) begin
        m_active <= 1'b0;
        m_count  <= m_count + CNT_W'(1);
      end
      m_c <= m_c + 1;
    end
  end

  always @(negedge clk) begin
    logic e_rl, e_re, e_fr, e_ov, e_ks;
    logic [AES_RND_W-1:0] e_rn;
    e_rl = m_active && (m_load > 0) && (m_c == m_load);
    e_re = m_active && (m_load > 0) && (m_c > m_load) && (m_c <= m_load + NR);
    e_rn = e_re ? AES_RND_W'(m_c - m_load) : '0;
    e_fr = e_re && (m_c - m_load == NR);
    e_ov = m_active && (m_load > 0) && (m_c > m_load + NR);
    e_ks = m_active && m_miss && (m_c == 1);
    chk("in_ready", in_ready, !m_active);
    chk("busy", busy, m_active);
    chk("kexp_start", kexp_start, e_ks);
    chk("round_load", round_load, e_rl);
    chk("round_en", round_en, e_re);
    chk("round_num", round_num, e_rn);
    chk("final_round", final_round, e_fr);
    chk("out_valid", out_valid, e_ov);
    chk("block_count", block_count, m_count);
  end

  // Key-expansion responder: done pulses kdelay cycles after kexp_start, or stays high when kdelay is 0
  initial forever begin
    @(negedge clk);
    if (kdelay == 0) begin
      kexp_done = 1'b1;
    end else if (kexp_start) begin
      repeat (kdelay) @(posedge clk);
      #1 kexp_done = 1'b1;
      @(posedge clk);
      #1 kexp_done = 1'b0;
    end else begin
      kexp_done = 1'b0;
    end
  end

  logic [4:0] q_rounds[$];
  always @(negedge clk) if (round_en) q_rounds.push_back({final_round, round_num});

  task automatic do_hs(input logic [127:0] key);
    bit hs = 1'b0;
    int g = 0;
    in_key   = key;
    in_valid = 1'b1;
    while (!hs && g < 100) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    in_valid = 1'b0;
    in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (!hs) timeout("handshake");
  endtask

  // Called in cycle 1; returns at the negedge of the first out_valid cycle
  task automatic run_blk(output int kp, output int ld, output int lat);
    kp = 0; ld = -1; lat = -1;
    for (int c = 1; c < 200 && lat < 0; c++) begin
      @(negedge clk);
      if (kexp_start) kp++;
      if (round_load) ld = c;
      if (out_valid) lat = c;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (lat < 0) timeout("out_valid");
  endtask

  task automatic send(input logic [127:0] key, output int kp, output int ld, output int lat);
    do_hs(key);
    run_blk(kp, ld, lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int kp, ld, lat, g;
    logic [127:0] key_c;
    key_c = 128'hcafe_f00d_0123_4567_89ab_cdef_5555_aaaa;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_block_count", block_count, 16'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // First block, kexp_done 3 cycles after the pulse
    q_rounds.delete();
    send(128'h000102030405060708090a0b0c0d0e0f, kp, ld, lat);
    chk("t1_kexp_pulses", kp, 1);
    chk("t1_load_cycle", ld, 5);
    chk("t1_out_latency", lat, 16);
    chk("t1_round_count", q_rounds.size(), 10);
    foreach (q_rounds[i]) chk("t1_round_seq", q_rounds[i], {(i == 9), 4'(i + 1)});
    @(negedge clk);
    chk("t1_block_count", block_count, 16'd1);
    chk("t1_out_valid_1cyc", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Backpressure with in_valid held high
    out_ready = 1'b0;
    do_hs(128'h1111_2222_3333_4444_5555_6666_7777_8888);
    run_blk(kp, ld, lat);
    in_valid = 1'b1;
    in_key   = 128'h9999;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_idle_after", in_ready, 1'b1);
    chk("bp_count", block_count, 16'd2);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_accepted", busy, 1'b1);
    @(posedge clk);
    #1;
    run_blk(kp, ld, lat);
    chk("bp_next_latency", lat, 15);
    @(posedge clk);
    #1;

    // Key reuse: hit skips expansion only with the cache built in
    send(key_c, kp, ld, lat);
    chk("c1_kexp_pulses", kp, 1);
    send(key_c, kp, ld, lat);
    chk("c2_kexp_pulses", kp, CACHE ? 0 : 1);
    chk("c2_out_latency", lat, CACHE ? 12 : 16);
    send({128{1'b1}}, kp, ld, lat);
    chk("c3_kexp_pulses", kp, 1);
    chk("c3_block_count", block_count, 16'd6);

    // kexp_done already high in the first KEXP cycle
    kdelay = 0;
    @(posedge clk);
    #1;
    send(128'h0d0d, kp, ld, lat);
    chk("early_done_load", ld, 2);
    chk("early_done_latency", lat, 13);
    kdelay = 3;
    @(posedge clk);
    #1;

    // Mid-operation reset at round 5
    do_hs(key_c);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(round_en && round_num == 4'd5) && g < 100);
    if (g >= 100) timeout("round5");
    #2 reset = 1'b0;
    #1;
    chk("ar_in_ready", in_ready, 1'b1);
    chk("ar_busy", busy, 1'b0);
    chk("ar_round_en", round_en, 1'b0);
    chk("ar_round_num", round_num, 4'd0);
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_block_count", block_count, 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    send(key_c, kp, ld, lat);
    chk("ar_cache_cold", kp, 1);
    chk("ar_count_after", block_count, 16'd1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
